// File: rtl/ch_elect_scan_if.sv
// Memory port bundle for the cluster-head election engine.
// The master drives address/strobe/write data; the slave returns read data.
interface ch_elect_scan_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 11
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] data_in;

    modport master (output address, output wr_en, output data_out, input data_in);
    modport slave  (input address, input wr_en, input data_out, output data_in);
endinterface

// File: rtl/ch_elect_scan.sv
// Cluster-head election engine: reads own ID/metric plus a neighbour table, writes the decision word.
// Macro CH_ELECT_THRESH_EN enables the CH_THRESH metric-eligibility rule.
module ch_elect_scan #(
    parameter int unsigned           DATA_WIDTH  = 16,
    parameter int unsigned           ADDR_WIDTH  = 11,
    parameter int unsigned           ID_WIDTH    = 8,
    parameter int unsigned           MAX_NBR     = 16,
    parameter int unsigned           ADDR_MY_ID  = 0,
    parameter int unsigned           ADDR_MY_MET = 1,
    parameter int unsigned           ADDR_NCOUNT = 2,
    parameter int unsigned           ADDR_NTABLE = 3,
    parameter int unsigned           ADDR_RESULT = 2047,
    parameter logic [DATA_WIDTH-1:0] CH_THRESH   = 16'h0010
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                en,
    ch_elect_scan_if.master     mem,
    output logic                is_ch,
    output logic                for_aggregation,
    output logic [ID_WIDTH-1:0] ch_id,
    output logic                nbr_ovf,
    output logic                busy,
    output logic                done
);
    localparam int unsigned NW = $clog2(MAX_NBR + 1);
    localparam int unsigned CW = NW + 1;

    typedef enum logic [2:0] {IDLE, HDR, SCAN, WRITE, DONE} state_t;

    state_t                state_q;
    logic [1:0]            step_q;
    logic [NW-1:0]         n_q;
    logic [CW-1:0]         rcv_q;
    logic                  ovf_q;
    logic                  own_elig_q;
    logic                  best_vld_q;
    logic [ID_WIDTH-1:0]   own_id_q;
    logic [ID_WIDTH-1:0]   best_id_q;
    logic [ID_WIDTH-1:0]   cand_id_q;
    logic [DATA_WIDTH-1:0] best_met_q;

    logic                  elig_c;
    logic                  replace_c;
    logic                  ovf_c;
    logic                  win_own_c;
    logic [NW-1:0]         n_c;
    logic [ID_WIDTH-1:0]   win_id_c;
    logic [DATA_WIDTH-1:0] word_c;

`ifdef CH_ELECT_THRESH_EN
    assign elig_c = (mem.data_in >= CH_THRESH);
`else
    logic unused_thresh;
    assign unused_thresh = ^CH_THRESH;
    assign elig_c        = 1'b1;
`endif

    // Count clamp, candidate ranking and decision word
    always_comb begin
        ovf_c     = (mem.data_in > DATA_WIDTH'(MAX_NBR));
        n_c       = ovf_c ? NW'(MAX_NBR) : NW'(mem.data_in);
        replace_c = elig_c && (!best_vld_q || (mem.data_in > best_met_q) ||
                    ((mem.data_in == best_met_q) && (cand_id_q < best_id_q)));
        win_own_c = own_elig_q && best_vld_q && (best_id_q == own_id_q);
        win_id_c  = best_vld_q ? best_id_q : '1;
        word_c                 = '0;
        word_c[DATA_WIDTH-1]   = win_own_c;
        word_c[ID_WIDTH-1:0]   = win_id_c;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q         <= IDLE;
            step_q          <= '0;
            n_q             <= '0;
            rcv_q           <= '0;
            ovf_q           <= 1'b0;
            own_elig_q      <= 1'b0;
            best_vld_q      <= 1'b0;
            own_id_q        <= '0;
            best_id_q       <= '0;
            cand_id_q       <= '0;
            best_met_q      <= '0;
            mem.address     <= '0;
            mem.wr_en       <= 1'b0;
            mem.data_out    <= '0;
            is_ch           <= 1'b0;
            for_aggregation <= 1'b0;
            ch_id           <= '0;
            nbr_ovf         <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= HDR;
                        step_q  <= '0;
                        busy    <= 1'b1;
                    end
                end
                // Header reads; each word is captured one cycle after its address
                HDR: begin
                    step_q <= step_q + 2'd1;
                    case (step_q)
                        2'd0: mem.address <= ADDR_WIDTH'(ADDR_MY_ID);
                        2'd1: begin
                            own_id_q    <= mem.data_in[ID_WIDTH-1:0];
                            best_id_q   <= mem.data_in[ID_WIDTH-1:0];
                            mem.address <= ADDR_WIDTH'(ADDR_MY_MET);
                        end
                        2'd2: begin
                            best_met_q  <= mem.data_in;
                            own_elig_q  <= elig_c;
                            best_vld_q  <= elig_c;
                            mem.address <= ADDR_WIDTH'(ADDR_NCOUNT);
                        end
                        default: begin
                            n_q         <= n_c;
                            ovf_q       <= ovf_c;
                            rcv_q       <= '0;
                            mem.address <= ADDR_WIDTH'(ADDR_NTABLE);
                            state_q     <= SCAN;
                        end
                    endcase
                end
                // Even words are IDs, odd words are metrics of the same entry
                SCAN: begin
                    if (rcv_q == {n_q, 1'b0}) begin
                        state_q      <= WRITE;
                        mem.wr_en    <= 1'b1;
                        mem.address  <= ADDR_WIDTH'(ADDR_RESULT);
                        mem.data_out <= word_c;
                    end else begin
                        rcv_q       <= rcv_q + CW'(1);
                        mem.address <= mem.address + ADDR_WIDTH'(1);
                        if (!rcv_q[0]) begin
                            cand_id_q <= mem.data_in[ID_WIDTH-1:0];
                        end else if (replace_c) begin
                            best_id_q  <= cand_id_q;
                            best_met_q <= mem.data_in;
                            best_vld_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state_q         <= DONE;
                    mem.wr_en       <= 1'b0;
                    mem.address     <= '0;
                    mem.data_out    <= '0;
                    done            <= 1'b1;
                    is_ch           <= win_own_c;
                    ch_id           <= win_id_c;
                    for_aggregation <= win_own_c && (n_q != '0);
                    nbr_ovf         <= ovf_q;
                end
                DONE: begin
                    state_q <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ch_elect_scan.sv
// Self-checking bench for ch_elect_scan: directed cases plus randomized tables against a reference model.
module tb_ch_elect_scan;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 11;
    localparam int unsigned IW = 8;
    localparam int unsigned MAXN = 16;

    logic          clock;
    logic          rst;
    logic          en;
    logic          is_ch;
    logic          for_aggregation;
    logic [IW-1:0] ch_id;
    logic          nbr_ovf;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [0:2047];
    logic [7:0]    tbl_id  [0:31];
    logic [15:0]   tbl_met [0:31];

    int n_tests;
    int n_fail;

    int          r_wr_cyc, r_done_cyc, r_nwr, r_ndone, r_busy_bad, r_dout_bad;
    logic [10:0] r_wr_addr;
    logic [15:0] r_wr_data;
    logic        r_is_ch, r_agg, r_ovf;
    logic [7:0]  r_ch_id;
    logic [10:0] addr_log [0:159];

    ch_elect_scan_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    assign bus.data_in = mem[bus.address];

    ch_elect_scan #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_NBR(MAXN)) dut (
        .clock(clock), .rst(rst), .en(en), .mem(bus),
        .is_ch(is_ch), .for_aggregation(for_aggregation), .ch_id(ch_id),
        .nbr_ovf(nbr_ovf), .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic eligible(input logic [15:0] m);
`ifdef CH_ELECT_THRESH_EN
        return m >= 16'h0010;
`else
        return 1'b1;
`endif
    endfunction

    // Winner = highest metric, ties to lowest ID, among eligible own + first n entries
    function automatic logic [15:0] model_word(input logic [7:0] oid, input logic [15:0] omet, input int n);
        logic       have;
        logic [7:0] bid;
        logic [15:0] bmet;
        logic       own_ok;
        own_ok = eligible(omet);
        have   = own_ok;
        bid    = oid;
        bmet   = omet;
        for (int i = 0; i < n; i++) begin
            if (eligible(tbl_met[i]) &&
                (!have || tbl_met[i] > bmet || (tbl_met[i] == bmet && tbl_id[i] < bid))) begin
                have = 1'b1;
                bid  = tbl_id[i];
                bmet = tbl_met[i];
            end
        end
        return {(own_ok && have && bid == oid), 7'd0, (have ? bid : 8'hFF)};
    endfunction

    task automatic load_mem(input logic [7:0] oid, input logic [15:0] omet, input logic [15:0] cnt, input int nent);
        for (int a = 0; a < 64; a++) mem[a] = 16'h0000;
        mem[0] = {8'h00, oid};
        mem[1] = omet;
        mem[2] = cnt;
        for (int i = 0; i < nent; i++) begin
            mem[3 + 2*i] = {8'h00, tbl_id[i]};
            mem[4 + 2*i] = tbl_met[i];
        end
    endtask

    // One run: en sampled at edge 0; cycle k observed at the negedge after edge k
    task automatic run_once(input int pulse_cyc, input int rst_cyc);
        r_wr_cyc = -1; r_done_cyc = -1; r_nwr = 0; r_ndone = 0; r_busy_bad = 0; r_dout_bad = 0;
        r_wr_addr = '0; r_wr_data = '0; r_is_ch = 1'b0; r_agg = 1'b0; r_ovf = 1'b0; r_ch_id = '0;
        for (int k = 0; k < 160; k++) addr_log[k] = '1;
        @(negedge clock);
        en = 1'b1;
        @(posedge clock);
        @(negedge clock);
        en = (pulse_cyc == 1);
        rst = (rst_cyc == 1);
        for (int k = 1; k < 160; k++) begin
            @(posedge clock);
            @(negedge clock);
            addr_log[k] = bus.address;
            if (bus.wr_en === 1'b1) begin
                r_nwr++;
                r_wr_cyc  = k;
                r_wr_addr = bus.address;
                r_wr_data = bus.data_out;
            end else if (bus.data_out !== '0) begin
                r_dout_bad++;
            end
            if ((rst_cyc == 0 || k < rst_cyc) && r_done_cyc < 0 && busy !== 1'b1) r_busy_bad++;
            if (r_done_cyc >= 0 && k == r_done_cyc + 1 && busy !== 1'b0) r_busy_bad++;
            if (done === 1'b1) begin
                r_ndone++;
                if (r_done_cyc < 0) begin
                    r_done_cyc = k;
                    r_is_ch = is_ch; r_agg = for_aggregation; r_ovf = nbr_ovf; r_ch_id = ch_id;
                end
            end
            en  = (k + 1 == pulse_cyc);
            rst = (k + 1 == rst_cyc);
            if (r_done_cyc >= 0 && k >= r_done_cyc + 3) break;
            if (rst_cyc > 0 && k >= rst_cyc + 4) break;
        end
        en  = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            @(negedge clock);
            n_tests++;
            if (bus.wr_en !== 1'b0 || bus.address !== 11'd0) begin
                n_fail++;
                $display("FAIL reset_mem_access cyc%0d: wr_en=%b address=%0d, required 0/0", c, bus.wr_en, bus.address);
            end
        end
        n_tests++;
        if ({is_ch, for_aggregation, ch_id, nbr_ovf, busy, done, bus.data_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: is_ch=%b agg=%b ch_id=%h ovf=%b busy=%b done=%b dout=%h, required all 0",
                     is_ch, for_aggregation, ch_id, nbr_ovf, busy, done, bus.data_out);
        end
        en  = 1'b0;
        rst = 1'b0;
        @(posedge clock);
        @(negedge clock);
        n_tests++;
        if (busy !== 1'b0 || bus.address !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b address=%0d, required 0/0", busy, bus.address);
        end
    endtask

    task automatic test_election();
        int bad;
        tbl_id[0] = 8'd2; tbl_met[0] = 16'h0040;
        tbl_id[1] = 8'd7; tbl_met[1] = 16'h0030;
        tbl_id[2] = 8'd9; tbl_met[2] = 16'h004F;
        load_mem(8'd5, 16'h0050, 16'd3, 3);
        run_once(0, 0);
        n_tests++;
        if (r_wr_cyc != 11 || r_nwr != 1 || r_wr_addr !== 11'd2047 || r_wr_data !== 16'h8005) begin
            n_fail++;
            $display("FAIL elect_write: cyc=%0d n=%0d addr=%0d data=%h, required 11 1 2047 8005", r_wr_cyc, r_nwr, r_wr_addr, r_wr_data);
        end
        n_tests++;
        if (r_done_cyc != 12 || r_ndone != 1) begin
            n_fail++;
            $display("FAIL elect_done: cyc=%0d count=%0d, required 12 1", r_done_cyc, r_ndone);
        end
        n_tests++;
        if (r_is_ch !== 1'b1 || r_agg !== 1'b1 || r_ch_id !== 8'd5 || r_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL elect_flags: is_ch=%b agg=%b ch_id=%0d ovf=%b, required 1 1 5 0", r_is_ch, r_agg, r_ch_id, r_ovf);
        end
        bad = 0;
        for (int j = 1; j <= 3; j++) if (addr_log[j] !== 11'(j - 1)) bad++;
        for (int j = 0; j < 6; j++) if (addr_log[4 + j] !== 11'(3 + j)) bad++;
        n_tests++;
        if (bad != 0 || r_busy_bad != 0 || r_dout_bad != 0) begin
            n_fail++;
            $display("FAIL elect_seq: addr_err=%0d busy_err=%0d dout_err=%0d, required 0 0 0", bad, r_busy_bad, r_dout_bad);
        end

        tbl_id[0] = 8'd3; tbl_met[0] = 16'h0050;
        load_mem(8'd5, 16'h0050, 16'd1, 1);
        run_once(0, 0);
        n_tests++;
        if (r_wr_cyc != 7 || r_wr_data !== 16'h0003 || r_done_cyc != 8) begin
            n_fail++;
            $display("FAIL tie_timing: wr=%0d data=%h done=%0d, required 7 0003 8", r_wr_cyc, r_wr_data, r_done_cyc);
        end
        n_tests++;
        if (r_is_ch !== 1'b0 || r_ch_id !== 8'd3 || r_agg !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_flags: is_ch=%b ch_id=%0d agg=%b, required 0 3 0", r_is_ch, r_ch_id, r_agg);
        end
    endtask

    task automatic test_count_bounds();
        int bad;
        logic [15:0] exp_w;
        load_mem(8'd5, 16'h0050, 16'd0, 0);
        run_once(0, 0);
        n_tests++;
        if (r_wr_cyc != 5 || r_wr_data !== 16'h8005 || r_done_cyc != 6 || r_nwr != 1) begin
            n_fail++;
            $display("FAIL empty_timing: wr=%0d data=%h done=%0d nwr=%0d, required 5 8005 6 1", r_wr_cyc, r_wr_data, r_done_cyc, r_nwr);
        end
        n_tests++;
        if (r_is_ch !== 1'b1 || r_agg !== 1'b0 || r_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_flags: is_ch=%b agg=%b ovf=%b, required 1 0 0", r_is_ch, r_agg, r_ovf);
        end

        for (int i = 0; i < 20; i++) begin
            tbl_id[i]  = 8'($urandom_range(0, 255));
            tbl_met[i] = 16'($urandom_range(0, 16'h00FF));
        end
        tbl_id[18] = 8'd1; tbl_met[18] = 16'hFFFF;
        load_mem(8'd40, 16'h0100, 16'd20, 20);
        exp_w = model_word(8'd40, 16'h0100, 16);
        run_once(0, 0);
        n_tests++;
        if (r_done_cyc != 38 || r_wr_cyc != 37 || r_wr_data !== exp_w || r_nwr != 1) begin
            n_fail++;
            $display("FAIL ovf_run: done=%0d wr=%0d data=%h nwr=%0d, required 38 37 %h 1", r_done_cyc, r_wr_cyc, r_wr_data, r_nwr, exp_w);
        end
        n_tests++;
        if (r_ovf !== 1'b1 || r_is_ch !== exp_w[15] || r_ch_id !== exp_w[7:0] || r_agg !== exp_w[15]) begin
            n_fail++;
            $display("FAIL ovf_flags: ovf=%b is_ch=%b ch_id=%h agg=%b, required 1 %b %h %b", r_ovf, r_is_ch, r_ch_id, r_agg, exp_w[15], exp_w[7:0], exp_w[15]);
        end
        bad = 0;
        for (int j = 0; j < 32; j++) if (addr_log[4 + j] !== 11'(3 + j)) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL ovf_addr: addr_err=%0d, required 0", bad);
        end
    endtask

    task automatic test_random();
        logic [7:0]  oid;
        logic [15:0] omet;
        logic [15:0] exp_w;
        int          cnt;
        int          n;
        for (int it = 0; it < 25; it++) begin
            oid  = 8'($urandom_range(0, 255));
            omet = (it % 3 == 0) ? 16'($urandom_range(0, 65535)) : 16'(8 * $urandom_range(0, 6));
            cnt  = (it % 5 == 0) ? 0 : int'($urandom_range(0, 20));
            for (int i = 0; i < 20; i++) begin
                tbl_id[i]  = 8'($urandom_range(0, 15));
                tbl_met[i] = 16'(8 * $urandom_range(0, 6));
            end
            n     = (cnt > int'(MAXN)) ? int'(MAXN) : cnt;
            exp_w = model_word(oid, omet, n);
            load_mem(oid, omet, 16'(cnt), cnt);
            run_once(0, 0);
            n_tests++;
            if (r_wr_data !== exp_w || r_nwr != 1 || r_wr_addr !== 11'd2047) begin
                n_fail++;
                $display("FAIL rand%0d_word: data=%h nwr=%0d addr=%0d, required %h 1 2047", it, r_wr_data, r_nwr, r_wr_addr, exp_w);
            end
            n_tests++;
            if (r_done_cyc != 2*n + 6 || r_wr_cyc != 2*n + 5 || r_ndone != 1 || r_busy_bad != 0) begin
                n_fail++;
                $display("FAIL rand%0d_timing: done=%0d wr=%0d ndone=%0d busy_err=%0d, required %0d %0d 1 0",
                         it, r_done_cyc, r_wr_cyc, r_ndone, r_busy_bad, 2*n + 6, 2*n + 5);
            end
            n_tests++;
            if (r_is_ch !== exp_w[15] || r_ch_id !== exp_w[7:0] || r_agg !== (exp_w[15] && n > 0) || r_ovf !== (cnt > int'(MAXN))) begin
                n_fail++;
                $display("FAIL rand%0d_flags: is_ch=%b ch_id=%h agg=%b ovf=%b, required %b %h %b %b",
                         it, r_is_ch, r_ch_id, r_agg, r_ovf, exp_w[15], exp_w[7:0], (exp_w[15] && n > 0), (cnt > int'(MAXN)));
            end
        end
    endtask

    task automatic test_abort();
        tbl_id[0] = 8'd2; tbl_met[0] = 16'h0040;
        tbl_id[1] = 8'd7; tbl_met[1] = 16'h0030;
        tbl_id[2] = 8'd9; tbl_met[2] = 16'h004F;
        load_mem(8'd5, 16'h0050, 16'd3, 3);
        run_once(0, 7);
        n_tests++;
        if (r_nwr != 0 || r_ndone != 0 || r_busy_bad != 0) begin
            n_fail++;
            $display("FAIL abort_activity: nwr=%0d ndone=%0d busy_err=%0d, required 0 0 0", r_nwr, r_ndone, r_busy_bad);
        end
        n_tests++;
        if ({is_ch, for_aggregation, ch_id, nbr_ovf, busy, done, bus.wr_en, bus.address, bus.data_out} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: is_ch=%b agg=%b ch_id=%h ovf=%b busy=%b done=%b wr=%b addr=%0d, required all 0",
                     is_ch, for_aggregation, ch_id, nbr_ovf, busy, done, bus.wr_en, bus.address);
        end
    endtask

    task automatic test_busy_en();
        load_mem(8'd5, 16'h0050, 16'd3, 3);
        run_once(3, 0);
        n_tests++;
        if (r_ndone != 1 || r_done_cyc != 12 || r_nwr != 1 || r_wr_data !== 16'h8005) begin
            n_fail++;
            $display("FAIL busy_en: ndone=%0d done=%0d nwr=%0d data=%h, required 1 12 1 8005", r_ndone, r_done_cyc, r_nwr, r_wr_data);
        end
    endtask

`ifdef CH_ELECT_THRESH_EN
    task automatic test_thresh();
        tbl_id[0] = 8'd3; tbl_met[0] = 16'h0005;
        load_mem(8'd5, 16'h0008, 16'd1, 1);
        run_once(0, 0);
        n_tests++;
        if (r_wr_data !== 16'h00FF || r_ch_id !== 8'hFF || r_is_ch !== 1'b0 || r_done_cyc != 8) begin
            n_fail++;
            $display("FAIL thresh: data=%h ch_id=%h is_ch=%b done=%0d, required 00FF FF 0 8", r_wr_data, r_ch_id, r_is_ch, r_done_cyc);
        end
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        en      = 1'b0;
        for (int a = 0; a < 2048; a++) mem[a] = 16'h0000;
        test_reset();
        test_election();
        test_count_bounds();
        test_random();
        test_abort();
        test_busy_en();
`ifdef CH_ELECT_THRESH_EN
        test_thresh();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
